unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one synchronous single-port memory between the core's instruction-fetch port and its data port. It sits between the core's imem/dmem interfaces and the memory, and grants at most one access per cycle. Data accesses have priority, bounded by an anti-starvation counter for fetch. Read responses are tagged and returned to the requester that issued them after a fixed latency.

## Interface
- READ_LATENCY, 1: memory read latency in cycles; legal 1..4.
- MAX_STARVE, 4: consecutive denied fetch cycles after which fetch wins the next arbitration; legal 1..15.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- iReq  in  1  fetch read request; held until iGnt
- iAddr  in  32  fetch address
- iFlush  in  1  discard all in-flight fetch responses (wrong-branch redirect)
- iGnt  out  1  fetch access issued this cycle
- iRvalid  out  1  fetch read data valid
- iRdata  out  32  fetch read data
- dReq  in  1  data request; held until dGnt
- dWe  in  1  1 = store, 0 = load
- dAddr  in  32  data address
- dWdata  in  32  store data
- dSize  in  3  access size/sign code, passed through unchanged
- dGnt  out  1  data access issued this cycle
- dRvalid  out  1  load data valid
- dRdata  out  32  load data
- memEn  out  1  memory access strobe
- memWe  out  1  memory write enable
- memAddr  out  32  memory address
- memWdata  out  32  memory write data
- memSize  out  3  memory access size
- memRdata  in  32  memory read data, valid READ_LATENCY cycles after a read strobe

## Operation
- Grant is combinational from the current requests and starveCnt. iGnt and dGnt are never both 1.
- Default priority: dReq wins. iGnt = iReq & (~dReq | starveCnt == MAX_STARVE). dGnt = dReq & ~iGnt.
- starveCnt (4 bits):
  - Cleared to 0 when iGnt or ~iReq.
  - Incremented when iReq & ~iGnt.
  - Saturates at MAX_STARVE.
- Memory drive:
  - memEn = iGnt | dGnt.
  - On iGnt: memAddr = iAddr, memWe = 0, memSize = 3'b010.
  - On dGnt: memAddr = dAddr, memWe = dWe, memWdata = dWdata, memSize = dSize.
  - When idle, memAddr, memWdata and memSize drive 0.
- Response tag pipe: READ_LATENCY stages of {valid, owner}, where owner 0 = I and 1 = D.
  - Stage 0 loads valid = memEn & ~memWe, with the owner of the granted access.
  - The pipe shifts every cycle.
  - Stores create no tag and produce no response.
- Pipe output stage:
  - iRvalid = valid & owner == I & ~iFlush.
  - dRvalid = valid & owner == D.
  - iRdata and dRdata both carry memRdata; only the valid flags select the recipient.
- iFlush in cycle t:
  - Clears valid on every I-owned tag at the next edge, including a fetch granted in cycle t.
  - Masks iRvalid in cycle t.
  - D tags are unaffected.
- Reset (rst high):
  - starveCnt = 0 and all tag-pipe valids = 0.
  - iGnt, dGnt and memEn are forced to 0 while rst is high, so no access issues during reset.
  - Reset mid-operation discards all in-flight responses; no rvalid asserts for accesses issued before reset.

## Timing
- Reset values: iGnt, dGnt, iRvalid, dRvalid, memEn and memWe are 0; iRdata, dRdata, memAddr, memWdata and memSize are 0 or don't-care (rdata follows memRdata).
- Grant latency: 0 cycles; a request seen in cycle t with no competitor is granted in cycle t.
- Read latency: a read granted in cycle t returns rvalid exactly in cycle t + READ_LATENCY.
- Write completes at the clock edge ending the grant cycle.
- Throughput: one access per cycle; back-to-back grants to the same or alternating requesters create no bubbles.
- A requester not granted must hold its request and payload stable; the arbiter does not latch requests.
- Worst-case fetch wait with continuous dReq: MAX_STARVE cycles, then one fetch grant, then the counter restarts.

## Test plan
- **Fetch only:** iReq = 1 with iAddr = 0x100, 0x104, 0x108 on consecutive cycles, READ_LATENCY = 1. Required: iGnt = 1 each cycle, memAddr follows iAddr, iRvalid = 1 at cycles t+1..t+3 with the matching memRdata.
- **Contention:** iReq and dReq held, dWe = 0, MAX_STARVE = 4. Required: dGnt for 4 cycles, iGnt on the 5th, then 4 more dGnt; iGnt and dGnt are never both 1.
- **Store:** dReq = 1, dWe = 1, dAddr = 0x200, dWdata = 0xDEADBEEF, dSize = 3'b010. Required: memEn = memWe = 1 with those values in the same cycle; dRvalid stays 0 for the next 4 cycles.
- **Flush:** READ_LATENCY = 3; fetch reads granted at t, t+1 and a load at t+2; iFlush pulsed at t+2. Required: no iRvalid at t+3 or t+4; dRvalid = 1 at t+5.
- **Reset mid-flight:** load granted at t with READ_LATENCY = 2; rst = 1 at t+1. Required: no dRvalid at t+2; memEn = 0 while rst is high; starveCnt = 0 after reset.
- **Latency sweep:** repeat the fetch-only scenario for READ_LATENCY = 1..4. Required: rvalid offset equals READ_LATENCY exactly, with no dropped or duplicated responses.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data ports with tagged read return
module unified_mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic        iFlush,
  output logic        iGnt,
  output logic        iRvalid,
  output logic [31:0] iRdata,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [2:0]  dSize,
  output logic        dGnt,
  output logic        dRvalid,
  output logic [31:0] dRdata,
  output logic        memEn,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [2:0]  memSize,
  input  logic [31:0] memRdata
);
  logic [3:0] starve_q, starve_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d, own_q, own_d;
  logic [READ_LATENCY:0] vld_in, own_in;
  always_comb begin
    iGnt = ~rst & iReq & (~dReq | (starve_q == 4'(MAX_STARVE)));
    dGnt = ~rst & dReq & ~iGnt;
    starve_d = (iGnt | ~iReq) ? 4'd0 : (starve_q == 4'(MAX_STARVE)) ? starve_q : starve_q + 4'd1;
    memEn = iGnt | dGnt;
    memWe = dGnt & dWe;
    memAddr = iGnt ? iAddr : dGnt ? dAddr : 32'd0;
    memWdata = dGnt ? dWdata : 32'd0;
    memSize = iGnt ? 3'b010 : dGnt ? dSize : 3'd0;
    vld_in = {vld_q, memEn & ~memWe};
    own_in = {own_q, dGnt};
    vld_d = vld_in[READ_LATENCY-1:0] & ~({READ_LATENCY{iFlush}} & ~own_in[READ_LATENCY-1:0]);
    own_d = own_in[READ_LATENCY-1:0];
    iRvalid = ~rst & vld_q[READ_LATENCY-1] & ~own_q[READ_LATENCY-1] & ~iFlush;
    dRvalid = ~rst & vld_q[READ_LATENCY-1] & own_q[READ_LATENCY-1];
  end
  assign iRdata = memRdata;
  assign dRdata = memRdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      vld_q <= '0;
      own_q <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: four arbiters (READ_LATENCY 1..4) on shared stimulus, checked against a queue-level model
module tb_unified_mem_arbiter;
  localparam int MAXS = 4;
  logic clk = 1'b0;
  logic rst, i_req, i_flush, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0] d_size;
  logic [3:0] i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we;
  logic [31:0] i_rdata [4];
  logic [31:0] d_rdata [4];
  logic [31:0] mem_addr [4];
  logic [31:0] mem_wdata [4];
  logic [31:0] mem_rdata [4];
  logic [2:0] mem_size [4];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int waited = 0;
  logic sv [4][8];
  logic so [4][8];
  logic [31:0] sd [4][8];
  logic exp_gi, exp_gd;
  logic [3:0] exp_irv, exp_drv;
  logic [31:0] exp_rd [4];

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {~a[15:0], a[31:16] ^ 16'h3C3C};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] rp [g+1];
    always @(posedge clk) begin
      rp[0] <= f(mem_addr[g]);
      for (int k = 1; k <= g; k++) rp[k] <= rp[k-1];
    end
    assign mem_rdata[g] = rp[g];
    unified_mem_arbiter #(.READ_LATENCY(g + 1), .MAX_STARVE(MAXS)) dut (
      .clk(clk), .rst(rst),
      .iReq(i_req), .iAddr(i_addr), .iFlush(i_flush), .iGnt(i_gnt[g]),
      .iRvalid(i_rvalid[g]), .iRdata(i_rdata[g]),
      .dReq(d_req), .dWe(d_we), .dAddr(d_addr), .dWdata(d_wdata), .dSize(d_size),
      .dGnt(d_gnt[g]), .dRvalid(d_rvalid[g]), .dRdata(d_rdata[g]),
      .memEn(mem_en[g]), .memWe(mem_we[g]), .memAddr(mem_addr[g]), .memWdata(mem_wdata[g]),
      .memSize(mem_size[g]), .memRdata(mem_rdata[g])
    );
  end

  always_comb begin
    exp_gi = !rst && i_req && (!d_req || waited >= MAXS);
    exp_gd = !rst && d_req && !exp_gi;
    exp_irv = '0;
    exp_drv = '0;
    for (int j = 0; j < 4; j++) begin
      exp_irv[j] = !rst && sv[j][cyc % 8] && !so[j][cyc % 8] && !i_flush;
      exp_drv[j] = !rst && sv[j][cyc % 8] && so[j][cyc % 8];
      exp_rd[j] = sd[j][cyc % 8];
    end
  end

  always @(posedge clk) begin
    waited <= rst ? 0 : (i_req && !exp_gi) ? ((waited < MAXS) ? waited + 1 : MAXS) : 0;
    for (int j = 0; j < 4; j++) begin
      for (int s = 0; s < 8; s++) sv[j][s] <= !rst && (s != cyc % 8) && !(i_flush && !so[j][s]) && sv[j][s];
      if ((exp_gi && !i_flush) || (exp_gd && !d_we)) begin
        sv[j][(cyc + j + 1) % 8] <= 1'b1;
        so[j][(cyc + j + 1) % 8] <= exp_gd;
        sd[j][(cyc + j + 1) % 8] <= f(exp_gi ? i_addr : d_addr);
      end
    end
    cyc <= cyc + 1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_req = 0; i_addr = 0; i_flush = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0;
  endtask

  task automatic idle(input int n);
    quiet();
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1; i_req = 1; d_req = 1; d_we = 1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      tests++; if (i_gnt[j] !== 1'b0) begin fails++; $display("FAIL reset_ignt[%0d] got %b exp 0", j, i_gnt[j]); end
      tests++; if (d_gnt[j] !== 1'b0) begin fails++; $display("FAIL reset_dgnt[%0d] got %b exp 0", j, d_gnt[j]); end
      tests++; if (mem_en[j] !== 1'b0 || mem_we[j] !== 1'b0) begin fails++; $display("FAIL reset_mem[%0d] got en=%b we=%b exp 0", j, mem_en[j], mem_we[j]); end
      tests++; if (i_rvalid[j] !== 1'b0 || d_rvalid[j] !== 1'b0) begin fails++; $display("FAIL reset_rvalid[%0d] got i=%b d=%b exp 0", j, i_rvalid[j], d_rvalid[j]); end
    end
    next_cycle();
    rst = 0;
    idle(2);
  endtask

  task automatic test_fetch_sweep();
    logic e;
    for (int k = 0; k < 8; k++) begin
      quiet();
      i_req = (k < 3);
      i_addr = (k < 3) ? 32'h100 + 32'(4 * k) : 32'd0;
      @(negedge clk);
      if (k < 3) begin
        tests++; if (i_gnt[0] !== 1'b1) begin fails++; $display("FAIL fetch_ignt k=%0d got %b exp 1", k, i_gnt[0]); end
        tests++; if (mem_addr[0] !== i_addr) begin fails++; $display("FAIL fetch_addr k=%0d got %h exp %h", k, mem_addr[0], i_addr); end
      end
      for (int j = 0; j < 4; j++) begin
        e = (k >= j + 1) && (k - j - 1 < 3);
        tests++; if (i_rvalid[j] !== e) begin fails++; $display("FAIL sweep_irvalid L=%0d k=%0d got %b exp %b", j + 1, k, i_rvalid[j], e); end
        if (e) begin
          tests++; if (i_rdata[j] !== f(32'h100 + 32'(4 * (k - j - 1)))) begin fails++; $display("FAIL sweep_irdata L=%0d k=%0d got %h exp %h", j + 1, k, i_rdata[j], f(32'h100 + 32'(4 * (k - j - 1)))); end
        end
        tests++; if (d_rvalid[j] !== 1'b0) begin fails++; $display("FAIL sweep_drvalid L=%0d k=%0d got %b exp 0", j + 1, k, d_rvalid[j]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic eg;
    quiet();
    i_req = 1; i_addr = 32'h180; d_req = 1; d_addr = 32'h280;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      eg = (k == 4) || (k == 9);
      for (int j = 0; j < 4; j++) begin
        tests++; if (i_gnt[j] !== eg) begin fails++; $display("FAIL cont_ignt[%0d] k=%0d got %b exp %b", j, k, i_gnt[j], eg); end
        tests++; if (d_gnt[j] !== !eg) begin fails++; $display("FAIL cont_dgnt[%0d] k=%0d got %b exp %b", j, k, d_gnt[j], !eg); end
      end
      next_cycle();
    end
    idle(6);
  endtask

  task automatic test_store();
    quiet();
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_size = 3'b010;
    @(negedge clk);
    tests++; if (d_gnt[0] !== 1'b1 || mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1) begin fails++; $display("FAIL store_strobe got gnt=%b en=%b we=%b exp 1", d_gnt[0], mem_en[0], mem_we[0]); end
    tests++; if (mem_addr[0] !== 32'h200 || mem_wdata[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL store_payload got %h/%h exp 00000200/deadbeef", mem_addr[0], mem_wdata[0]); end
    tests++; if (mem_size[0] !== 3'b010) begin fails++; $display("FAIL store_size got %b exp 010", mem_size[0]); end
    next_cycle();
    quiet();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        tests++; if (d_rvalid[j] !== 1'b0) begin fails++; $display("FAIL store_drvalid L=%0d k=%0d got %b exp 0", j + 1, k, d_rvalid[j]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    logic ei, ed;
    for (int k = 0; k < 8; k++) begin
      quiet();
      if (k < 2) begin i_req = 1; i_addr = 32'h300 + 32'(4 * k); end
      if (k == 2) begin d_req = 1; d_addr = 32'h400; i_flush = 1; end
      @(negedge clk);
      if (k == 2) begin
        tests++; if (d_gnt[0] !== 1'b1) begin fails++; $display("FAIL flush_dgnt got %b exp 1", d_gnt[0]); end
      end
      for (int j = 0; j < 4; j++) begin
        ei = (j == 0) && (k == 1);
        ed = (k == 3 + j);
        tests++; if (i_rvalid[j] !== ei) begin fails++; $display("FAIL flush_irvalid L=%0d k=%0d got %b exp %b", j + 1, k, i_rvalid[j], ei); end
        tests++; if (d_rvalid[j] !== ed) begin fails++; $display("FAIL flush_drvalid L=%0d k=%0d got %b exp %b", j + 1, k, d_rvalid[j], ed); end
        if (ed) begin
          tests++; if (d_rdata[j] !== f(32'h400)) begin fails++; $display("FAIL flush_drdata L=%0d got %h exp %h", j + 1, d_rdata[j], f(32'h400)); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 12; k++) begin
      quiet();
      rst = (k == 3);
      i_req = 1; i_addr = 32'h600; d_req = 1; d_addr = 32'h500;
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (k == 3) begin
          tests++; if (mem_en[j] !== 1'b0) begin fails++; $display("FAIL rstmid_memen[%0d] got %b exp 0", j, mem_en[j]); end
        end
        if (k >= 4) begin
          tests++; if (i_gnt[j] !== (k == 8)) begin fails++; $display("FAIL rstmid_ignt[%0d] k=%0d got %b exp %b", j, k, i_gnt[j], k == 8); end
        end
        if (k >= 3 && k <= 4 + j) begin
          tests++; if (d_rvalid[j] !== 1'b0) begin fails++; $display("FAIL rstmid_drvalid L=%0d k=%0d got %b exp 0", j + 1, k, d_rvalid[j]); end
        end
      end
      next_cycle();
    end
    rst = 0;
    idle(6);
  endtask

  task automatic test_random();
    logic gi = 1'b0;
    logic gd = 1'b0;
    quiet();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!i_req || gi) begin i_req = 1'($urandom); i_addr = $urandom & 32'hFFFF_FFFC; end
      if (!d_req || gd) begin
        d_req = 1'($urandom); d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_size = 3'($urandom);
      end
      i_flush = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        tests++; if (i_gnt[j] !== exp_gi || d_gnt[j] !== exp_gd) begin fails++; $display("FAIL rnd_gnt L=%0d k=%0d got i=%b d=%b exp i=%b d=%b", j + 1, k, i_gnt[j], d_gnt[j], exp_gi, exp_gd); end
        tests++; if (mem_en[j] !== (exp_gi | exp_gd) || mem_we[j] !== (exp_gd & d_we)) begin fails++; $display("FAIL rnd_mem L=%0d k=%0d got en=%b we=%b exp en=%b we=%b", j + 1, k, mem_en[j], mem_we[j], exp_gi | exp_gd, exp_gd & d_we); end
        if (exp_gi || exp_gd) begin
          tests++; if (mem_addr[j] !== (exp_gi ? i_addr : d_addr)) begin fails++; $display("FAIL rnd_addr L=%0d k=%0d got %h exp %h", j + 1, k, mem_addr[j], exp_gi ? i_addr : d_addr); end
        end
        tests++; if (i_rvalid[j] !== exp_irv[j] || d_rvalid[j] !== exp_drv[j]) begin fails++; $display("FAIL rnd_rvalid L=%0d k=%0d got i=%b d=%b exp i=%b d=%b", j + 1, k, i_rvalid[j], d_rvalid[j], exp_irv[j], exp_drv[j]); end
        if (exp_irv[j] || exp_drv[j]) begin
          tests++; if ((exp_irv[j] ? i_rdata[j] : d_rdata[j]) !== exp_rd[j]) begin fails++; $display("FAIL rnd_rdata L=%0d k=%0d got %h exp %h", j + 1, k, exp_irv[j] ? i_rdata[j] : d_rdata[j], exp_rd[j]); end
        end
      end
      gi = exp_gi;
      gd = exp_gd;
      next_cycle();
    end
    rst = 0;
    idle(6);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    quiet();
    repeat (2) next_cycle();
    test_reset();
    test_fetch_sweep();
    test_contention();
    test_store();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
